debounce_sync: RTL
==================

// Module: debounce_sync
// PURPOSE
//   Conditions a raw asynchronous level (pushbutton, switch, off-chip strobe) before it drives
//   the d input of the team's D flip-flop stage.
//   - Multi-stage synchronizer, then a stability-count filter.
//   - Output q/qbar changes only after the synchronized input has held a new value for
//     STABLE_CYCLES enabled samples.
//   - Optional one-cycle rise/fall pulses for edge-triggered consumers.
// PARAMETERS
//   SYNC_STAGES    2   synchronizer flops on din; legal range >= 2
//   CNT_W          4   stability counter width
//   STABLE_CYCLES  10  enabled samples of a new value required before q updates;
//                      legal range 1 .. 2**CNT_W-1
// PORTS
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous, active-low reset
//   din   in   1  raw asynchronous input level
//   ce    in   1  sample enable (1 = sample every clk; tie 1 or drive with a prescaler tick)
//   q     out  1  filtered level
//   qbar  out  1  always ~q
//   busy  out  1  1 while a candidate change is being counted
//   rise  out  1  one-clk pulse on a q 0->1 transition (only with DEBOUNCE_EDGE_EN)
//   fall  out  1  one-clk pulse on a q 1->0 transition (only with DEBOUNCE_EDGE_EN)
// BEHAVIOUR
//   Reset (rst=0, asynchronous)
//   - Sync chain = 0, cnt = 0, state = IDLE.
//   - Outputs: q=0, qbar=1, busy=0, rise=0, fall=0.
//   - Reset asserted mid-count discards the count immediately.
//   Synchronizer
//   - Shift chain clocked every clk, not gated by ce; s = last stage.
//   State machine (updates only on edges with ce=1; ce=0 holds state and cnt)
//   - IDLE, s==q: stay in IDLE; cnt = 0.
//   - IDLE, s!=q, STABLE_CYCLES==1: q <= s; stay in IDLE.
//   - IDLE, s!=q, otherwise: cnt <= 1; go to COUNT.
//   - COUNT, s==q: glitch rejected; cnt <= 0; go to IDLE; q unchanged.
//   - COUNT, s!=q, cnt < STABLE_CYCLES-1: cnt <= cnt+1.
//   - COUNT, s!=q, cnt == STABLE_CYCLES-1: q <= s; cnt <= 0; go to IDLE.
//   - cnt never exceeds STABLE_CYCLES-1; no wrap.
//   Outputs
//   - busy: registered, equals (state==COUNT).
//   - qbar: registered complement of q; never equal to q.
//   Latency (ce tied 1, din step held stable)
//   - q updates on the (SYNC_STAGES + STABLE_CYCLES)-th rising clk edge after the step.
//   - A change lasting fewer than STABLE_CYCLES synchronized samples never reaches q.
//   - If din toggles back while in COUNT, the filter returns to IDLE on the next ce edge.
//   Simultaneous events
//   - ce=0 on the edge where s reverts: no glitch check, cnt holds.
//     The next ce edge evaluates s vs q.
// CONFIGURATION
//   DEBOUNCE_EDGE_EN
//   - Defined: rise/fall are registered and asserted for exactly one clk, on the same edge
//     that q changes (rise when q goes 0->1, fall when q goes 1->0). Never both at once.
//   - Undefined: rise and fall are constant 0 and the edge logic is absent.
//     q, qbar and busy behave identically in both builds.
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4, ce=1 unless stated)
//   1. Reset held with din=1, then released:
//      - q=0, qbar=1, busy=0 during reset.
//      - q=1 on the 6th edge after release.
//   2. din 0->1, held:
//      - busy=1 for 3 cycles.
//      - q=1, qbar=0 on the 6th edge.
//      - rise=1 for exactly that cycle (EN build).
//   3. din high 2 cycles, then low:
//      - q stays 0, no rise.
//      - busy returns 0 on the edge after s reverts.
//   4. ce high 1 cycle in every 4, din 0->1 held:
//      - q=1 only after the 4th ce-qualified sample, about 16 clks after s changes.
//   5. rst pulsed low mid-COUNT with q=1, din=0:
//      - q=0, qbar=1, cnt=0, busy=0 immediately, without waiting for a clk edge.
//   6. Build without DEBOUNCE_EDGE_EN, replay scenario 2:
//      - rise=fall=0 throughout.
//      - q timing identical to scenario 2.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronizer plus stability-count filter for a raw asynchronous level.
// Define DEBOUNCE_EDGE_EN to get registered one-clock rise/fall pulses on q transitions.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 4,
    parameter int STABLE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic ce,
    output logic q,
    output logic qbar,
    output logic busy,
    output logic rise,
    output logic fall
);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       COUNT    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit               SINGLE   = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   qbar_q, qbar_d;
    logic                   busy_q, busy_d;

    // The synchronizer runs every clock; only the filter honours ce.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (s != q_q) begin
                        if (SINGLE) begin
                            q_d = s;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = COUNT;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                COUNT: begin
                    if (s == q_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        q_d     = s;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
        qbar_d = ~q_d;
        busy_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qbar_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses register on the same edge that q itself changes.
    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
